sw_tx_scheduler: RTL

- Sequences the SRIO SWRITE transmit engine.
- Accepts one transfer descriptor (source, destination, length in 64-bit beats, mode) and splits it into SWRITE packets of at most 32 beats (256 B). Packets never cross a 256 B destination boundary and, in mm2sw mode, never cross a 4 KB AXI source boundary.
- For each packet it issues an AXI read-address request (mm2sw mode only), pulses sw_start toward the TX engine, then waits for sw_done.
- Sits between the PCIe-side command logic and the TX engine; the engine's AXI R channel is driven by the slave that receives this block's AR requests.

---
 rtl/sw_tx_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sw_tx_scheduler.sv
// SWRITE transmit scheduler: splits one descriptor into boundary-safe packets for the TX engine.
// Define SW_TX_SCHED_STATS_EN to add packet/transfer statistics counters.
module sw_tx_scheduler #(
    parameter int unsigned C_MAX_BEATS    = 32,
    parameter int unsigned C_DST_BOUNDARY = 256,
    parameter int unsigned C_SRC_BOUNDARY = 4096
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic        desc_mode,
    input  logic [31:0] desc_src_addr,
    input  logic [31:0] desc_dst_addr,
    input  logic [15:0] desc_len,
    output logic        sw_start,
    output logic        sw_mode,
    output logic [4:0]  sw_size,
    output logic [31:0] sw_addr,
    input  logic        sw_done,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic        busy,
    output logic        xfer_done
`ifdef SW_TX_SCHED_STATS_EN
    ,
    output logic [31:0] stat_pkt_cnt,
    output logic [31:0] stat_xfer_cnt
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_AR    = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [31:0] MaxBeats = 32'(C_MAX_BEATS);
    localparam logic [31:0] DstBnd   = 32'(C_DST_BOUNDARY);
    localparam logic [31:0] SrcBnd   = 32'(C_SRC_BOUNDARY);

    logic [2:0]  state_q, state_d;
    logic        mode_q, mode_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] chunk_q, chunk_d;
    logic [4:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;

    logic [31:0] dst_room, src_room, lim;
    logic [15:0] chunk_calc;

    // Beats left before the next destination / source boundary.
    always_comb begin
        dst_room = (DstBnd - (dst_q & (DstBnd - 32'd1))) >> 3;
        src_room = (SrcBnd - (src_q & (SrcBnd - 32'd1))) >> 3;
        lim = MaxBeats;
        if (dst_room < lim) lim = dst_room;
        if (mode_q && (src_room < lim)) lim = src_room;
        if ({16'd0, rem_q} < lim) lim = {16'd0, rem_q};
        chunk_calc = lim[15:0];
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rem_d    = rem_q;
        chunk_d  = chunk_q;
        size_d   = size_q;
        addr_d   = addr_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        case (state_q)
            S_IDLE: begin
                if (desc_valid) begin
                    mode_d  = desc_mode;
                    src_d   = desc_src_addr & ~32'h7;
                    dst_d   = desc_dst_addr & ~32'h7;
                    rem_d   = desc_len;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (rem_q == 16'd0) begin
                    state_d = S_DONE;
                end else begin
                    chunk_d  = chunk_calc;
                    size_d   = 5'(chunk_calc - 16'd1);
                    addr_d   = dst_q;
                    araddr_d = src_q;
                    arlen_d  = 8'(chunk_calc - 16'd1);
                    state_d  = mode_q ? S_AR : S_START;
                end
            end
            S_AR: begin
                if (m_axi_arready) state_d = S_START;
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (sw_done) begin
                    rem_d   = rem_q - chunk_q;
                    dst_d   = dst_q + {13'd0, chunk_q, 3'b000};
                    src_d   = src_q + {13'd0, chunk_q, 3'b000};
                    state_d = S_CALC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            src_q    <= 32'd0;
            dst_q    <= 32'd0;
            rem_q    <= 16'd0;
            chunk_q  <= 16'd0;
            size_q   <= 5'd0;
            addr_q   <= 32'd0;
            araddr_q <= 32'd0;
            arlen_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            chunk_q  <= chunk_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
        end
    end

    assign desc_ready    = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign sw_start      = (state_q == S_START);
    assign m_axi_arvalid = (state_q == S_AR);
    assign xfer_done     = (state_q == S_DONE);
    assign sw_mode       = mode_q;
    assign sw_size       = size_q;
    assign sw_addr       = addr_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;

`ifdef SW_TX_SCHED_STATS_EN
    logic [31:0] pkt_cnt_q, xfer_cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_cnt_q  <= 32'd0;
            xfer_cnt_q <= 32'd0;
        end else begin
            if ((state_q == S_WAIT) && sw_done) pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (state_q == S_DONE) xfer_cnt_q <= xfer_cnt_q + 32'd1;
        end
    end

    assign stat_pkt_cnt  = pkt_cnt_q;
    assign stat_xfer_cnt = xfer_cnt_q;
`endif

endmodule
